mult32x32_stream: RTL and testbench

- Upstream/downstream wrapper stage for the 32x32 sequential multiplier.
- Accepts operand pairs on a valid/ready stream and buffers them in a small FIFO.
- Issues one start pulse per pair to the multiplier, holding its a/b stable for the whole computation.
- Captures the 64-bit product when busy falls and presents it, with a tag, on an output valid/ready stream.

---
 rtl/mult32x32_stream_pkg.sv | 21 ++
 rtl/mult_op_fifo.sv | 72 +++++++
 rtl/mult32x32_stream.sv | 133 +++++++++++++
 tb/tb_mult32x32_stream.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult32x32_stream_pkg.sv
// Shared types and constants for the streaming wrapper around the 32x32 sequential multiplier.
package mult32x32_stream_pkg;

    localparam int OPERAND_W = 32;
    localparam int PRODUCT_W = 64;
    localparam int OP_TAG_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        ARM   = 2'd2,
        RUN   = 2'd3
    } state_t;

    typedef struct packed {
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
        logic [OP_TAG_W-1:0]  tag;
    } op_t;

endpackage

// File: rtl/mult_op_fifo.sv
// Operand-pair FIFO: circular buffer with occupancy count; push is ignored when full, pop when empty.
module mult_op_fifo
    import mult32x32_stream_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type elem_t = op_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  elem_t                  push_data,
    input  logic                   pop,
    output elem_t                  head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    elem_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Power-of-two depth lets the pointers wrap on their own width.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mult32x32_stream.sv
// Stream wrapper: buffers operand pairs, sequences one multiplier op at a time, and
// presents each 64-bit product with its tag on a valid/ready output.
module mult32x32_stream
    import mult32x32_stream_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [OPERAND_W-1:0]   in_a,
    input  logic [OPERAND_W-1:0]   in_b,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PRODUCT_W-1:0]   out_product,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   mult_start,
    output logic [OPERAND_W-1:0]   mult_a,
    output logic [OPERAND_W-1:0]   mult_b,
    input  logic                   mult_busy,
    input  logic [PRODUCT_W-1:0]   mult_product,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            ops_done
);

    typedef struct packed {
        logic [OPERAND_W-1:0] a;
        logic [OPERAND_W-1:0] b;
        logic [TAG_W-1:0]     tag;
    } stream_op_t;

    state_t               state_q, state_d;
    stream_op_t           op_q, op_d;
    logic                 out_valid_q, out_valid_d;
    logic [PRODUCT_W-1:0] out_product_q, out_product_d;
    logic [TAG_W-1:0]     out_tag_q, out_tag_d;
    logic [15:0]          ops_done_q, ops_done_d;

    stream_op_t fifo_in, fifo_head;
    logic       fifo_pop, fifo_full, fifo_empty;

    assign fifo_in = '{a: in_a, b: in_b, tag: in_tag};

    mult_op_fifo #(
        .DEPTH  (DEPTH),
        .elem_t (stream_op_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_valid && in_ready),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign in_ready    = !fifo_full;
    assign mult_a      = op_q.a;
    assign mult_b      = op_q.b;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign out_tag     = out_tag_q;
    assign ops_done    = ops_done_q;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        out_tag_d     = out_tag_q;
        ops_done_d    = ops_done_q;
        fifo_pop      = 1'b0;
        mult_start    = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            // Only launch when the result slot will be free by completion time.
            IDLE: begin
                if (!fifo_empty && (!out_valid_q || out_ready)) begin
                    fifo_pop = 1'b1;
                    op_d     = fifo_head;
                    state_d  = START;
                end
            end
            START: begin
                mult_start = 1'b1;
                state_d    = ARM;
            end
            ARM: begin
                if (mult_busy) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!mult_busy) begin
                    out_valid_d   = 1'b1;
                    out_product_d = mult_product;
                    out_tag_d     = op_q.tag;
                    ops_done_d    = ops_done_q + 16'd1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            op_q          <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_tag_q     <= '0;
            ops_done_q    <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            out_tag_q     <= out_tag_d;
            ops_done_q    <= ops_done_d;
        end
    end

endmodule

// File: tb/tb_mult32x32_stream.sv
// Self-checking bench for mult32x32_stream with a behavioural sequential multiplier attached.
module tb_mult32x32_stream;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_a = '0;
    logic [31:0]      in_b = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0]      out_product;
    logic [TAG_W-1:0] out_tag;
    logic             mult_start;
    logic [31:0]      mult_a, mult_b;
    logic             mult_busy;
    logic [63:0]      mult_product;
    logic [CW-1:0]    fifo_count;
    logic [15:0]      ops_done;

    always #5 clk = ~clk;

    mult32x32_stream #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_product  (out_product),
        .out_tag      (out_tag),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_busy    (mult_busy),
        .mult_product (mult_product),
        .fifo_count   (fifo_count),
        .ops_done     (ops_done)
    );

    // Behavioural multiplier: busy for a configurable number of cycles after start.
    logic        busy_m = 1'b0;
    logic [63:0] prod_m = '0;
    logic [31:0] ma_m = '0, mb_m = '0;
    int          cnt_m = 0;
    int          lat_cfg = 0;

    assign mult_busy    = busy_m;
    assign mult_product = prod_m;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_m <= 1'b0;
            prod_m <= '0;
            cnt_m  <= 0;
        end else if (mult_start) begin
            busy_m <= 1'b1;
            cnt_m  <= (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 6));
            ma_m   <= mult_a;
            mb_m   <= mult_b;
        end else if (busy_m) begin
            if (cnt_m <= 1) begin
                busy_m <= 1'b0;
                prod_m <= 64'(mult_a) * 64'(mult_b);
            end
            cnt_m <= cnt_m - 1;
        end
    end

    typedef struct packed {
        logic [63:0]      p;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t             exp_q[$];
    exp_t             exp_e;
    int               checks = 0;
    int               failures = 0;
    int               results_seen = 0;
    int               starts_seen = 0;
    logic [63:0]      last_prod = '0;
    logic [TAG_W-1:0] last_tag = '0;
    logic             hold_pending = 1'b0;
    logic [63:0]      hold_p = '0;
    logic [TAG_W-1:0] hold_t = '0;
    logic [15:0]      ops_exp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard: every accepted input yields exactly one a*b result, in order.
    always @(negedge clk) begin
        if (!reset) begin
            hold_pending = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_e.p   = 64'(in_a) * 64'(in_b);
                exp_e.tag = in_tag;
                exp_q.push_back(exp_e);
            end
            if (mult_start) starts_seen++;
            if (busy_m) begin
                check("mult_a_stable", 64'(mult_a), 64'(ma_m));
                check("mult_b_stable", 64'(mult_b), 64'(mb_m));
            end
            if (hold_pending && out_valid) begin
                check("out_product_held", out_product, hold_p);
                check("out_tag_held", 64'(out_tag), 64'(hold_t));
            end
            hold_pending = out_valid && !out_ready;
            hold_p       = out_product;
            hold_t       = out_tag;
            if (out_valid && out_ready) begin
                results_seen++;
                last_prod = out_product;
                last_tag  = out_tag;
                $display("result %0d product=0x%h tag=%0d ops_done=%0d",
                         results_seen, out_product, out_tag, ops_done);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=0x%h required=none", out_product);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("sb_product", out_product, exp_e.p);
                    check("sb_tag", 64'(out_tag), 64'(exp_e.tag));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        int budget;
        budget   = 300;
        in_a     = a;
        in_b     = b;
        in_tag   = t;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=in_ready=0 required=in_ready=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (results_seen < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(results_seen), 64'(target));
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        ops_exp  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
    endtask

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [63:0]      p;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, s0;
        vecs[0] = '{32'd3,         32'd5,         4'd1,  64'h0000_0000_0000_000F};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2,  64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'd0,         32'hDEAD_BEEF, 4'd3,  64'h0};
        vecs[3] = '{32'h8000_0000, 32'd2,         4'd4,  64'h0000_0001_0000_0000};
        vecs[4] = '{32'h1234_5678, 32'd1,         4'd5,  64'h0000_0000_1234_5678};
        vecs[5] = '{32'hFFFF_FFFF, 32'd2,         4'd15, 64'h0000_0001_FFFF_FFFE};

        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_ops_done", 64'(ops_done), 64'd0);
        check("rst_mult_start", 64'(mult_start), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors, one at a time with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            r0 = results_seen;
            s0 = starts_seen;
            push_op(vecs[i].a, vecs[i].b, vecs[i].tag);
            wait_results(r0 + 1, 100, "vec_result_arrived");
            repeat (3) tick();
            ops_exp++;
            check("vec_product", last_prod, vecs[i].p);
            check("vec_tag", 64'(last_tag), 64'(vecs[i].tag));
            check("vec_start_pulses", 64'(starts_seen - s0), 64'd1);
            check("vec_result_count", 64'(results_seen - r0), 64'd1);
            check("vec_ops_done", 64'(ops_done), 64'(ops_exp));
        end

        // Randomised traffic with random backpressure.
        r0 = results_seen;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    push_op($urandom, $urandom, TAG_W'($urandom_range(0, 15)));
                end
            end
            begin
                for (int n = 0; n < 3000 && results_seen < r0 + 40; n++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        wait_results(r0 + 40, 400, "rand_all_results");
        repeat (3) tick();
        ops_exp += 16'd40;
        check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
        check("rand_ops_done", 64'(ops_done), 64'(ops_exp));

        // Fill with the consumer stalled: one result parks, the FIFO fills, input stalls.
        out_ready = 1'b0;
        r0 = results_seen;
        s0 = starts_seen;
        for (int i = 0; i < 5; i++) begin
            push_op(32'(i + 1), 32'(i + 10), TAG_W'(i + 1));
        end
        in_a = 32'd6; in_b = 32'd15; in_tag = 4'd6; in_valid = 1'b1;
        repeat (20) tick();
        check("stall_fifo_full", 64'(fifo_count), 64'd4);
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("stall_out_valid", 64'(out_valid), 64'd1);
        check("stall_starts", 64'(starts_seen - s0), 64'd1);
        check("stall_ops_done", 64'(ops_done), 64'(ops_exp + 16'd1));
        // Drain one result: pop and a blocked push land on the same edge.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_pop_count", 64'(fifo_count), 64'd3);
        check("full_pop_in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("late_push_count", 64'(fifo_count), 64'd4);
        out_ready = 1'b1;
        wait_results(r0 + 6, 300, "stall_all_results");
        repeat (3) tick();
        ops_exp += 16'd6;
        check("stall_queue_empty", 64'(exp_q.size()), 64'd0);
        check("stall_ops_done", 64'(ops_done), 64'(ops_exp));

        // Asynchronous reset while the multiplier is running.
        lat_cfg = 6;
        in_a = 32'd100; in_b = 32'd200; in_tag = 4'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int n = 0; n < 20 && !busy_m; n++) tick();
        tick();
        check("pre_reset_busy", 64'(busy_m), 64'd1);
        reset = 1'b0;
        exp_q.delete();
        ops_exp = '0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_product", out_product, 64'd0);
        check("arst_out_tag", 64'(out_tag), 64'd0);
        check("arst_mult_a", 64'(mult_a), 64'd0);
        check("arst_mult_b", 64'(mult_b), 64'd0);
        check("arst_ops_done", 64'(ops_done), 64'd0);
        check("arst_fifo_count", 64'(fifo_count), 64'd0);
        repeat (2) tick();
        reset = 1'b1;
        r0 = results_seen;
        repeat (20) tick();
        check("arst_no_result", 64'(results_seen), 64'(r0));
        check("arst_out_valid_after", 64'(out_valid), 64'd0);
        lat_cfg = 0;
        push_op(32'd7, 32'd9, 4'd9);
        wait_results(r0 + 1, 100, "post_reset_result");
        repeat (3) tick();
        check("post_reset_product", last_prod, 64'd63);
        check("post_reset_tag", 64'(last_tag), 64'd9);

        // ops_done wrap: preload near the top while idle, then complete two ops.
        force dut.ops_done_q = 16'hFFFE;
        tick();
        release dut.ops_done_q;
        tick();
        r0 = results_seen;
        push_op(32'd2, 32'd3, 4'd1);
        wait_results(r0 + 1, 100, "wrap_result1");
        repeat (3) tick();
        check("ops_done_ffff", 64'(ops_done), 64'hFFFF);
        push_op(32'd4, 32'd5, 4'd2);
        wait_results(r0 + 2, 100, "wrap_result2");
        repeat (3) tick();
        check("ops_done_wrap", 64'(ops_done), 64'h0000);
        check("wrap_product", last_prod, 64'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
